// File: rtl/petris_pkg.sv
// ============================================================================
// Module      : petris_pkg
// Description : Shared playfield geometry defaults, action bit positions and
//               the frame sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package petris_pkg;

  localparam int DEF_COLS = 10;
  localparam int DEF_ROWS = 20;
  localparam int DEF_CW   = 3;

  localparam int ACT_RIGHT  = 0;
  localparam int ACT_LEFT   = 1;
  localparam int ACT_ROTATE = 2;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_COPY  = 2'd2
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/playfield_frame_sequencer_if.sv
// ============================================================================
// Module      : playfield_frame_sequencer_if
// Description : Back-buffer write bus and front-buffer read bus between the
//               tetrimino writer / VGA reader (master) and the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface playfield_frame_sequencer_if
  import petris_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int CW   = DEF_CW
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic             wr_en;
  logic [COL_W-1:0] wr_col;
  logic [ROW_W-1:0] wr_row;
  logic [CW-1:0]    wr_data;
  logic             wr_ready;
  logic             commit;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;
  logic [CW-1:0]    rd_pixel;

  modport master (
    output wr_en, wr_col, wr_row, wr_data, commit, rd_col, rd_row,
    input  wr_ready, rd_pixel
  );

  modport slave (
    input  wr_en, wr_col, wr_row, wr_data, commit, rd_col, rd_row,
    output wr_ready, rd_pixel
  );

endinterface

`default_nettype wire

// File: rtl/playfield_bank_ram.sv
// ============================================================================
// Module      : playfield_bank_ram
// Description : Two playfield banks with one write port and two synchronous
//               read ports (VGA read, copy read).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module playfield_bank_ram #(
  parameter  int CELLS = 200,
  parameter  int CW    = 3,
  localparam int IW    = $clog2(CELLS)
) (
  input  wire logic          clock,
  input  wire logic          reset,
  input  wire logic          i_wr_en,
  input  wire logic          i_wr_both,
  input  wire logic          i_wr_bank,
  input  wire logic [IW-1:0] i_wr_idx,
  input  wire logic [CW-1:0] i_wr_data,
  input  wire logic          i_vga_bank,
  input  wire logic [IW-1:0] i_vga_idx,
  input  wire logic          i_vga_ok,
  output logic      [CW-1:0] o_vga_q,
  input  wire logic          i_cp_bank,
  input  wire logic [IW-1:0] i_cp_idx,
  output logic      [CW-1:0] o_cp_q
);

  logic [CW-1:0] r_bank0 [CELLS];
  logic [CW-1:0] r_bank1 [CELLS];
  logic          w_cp_hit;

  always_ff @(posedge clock) begin
    if (i_wr_en && (i_wr_both || !i_wr_bank)) r_bank0[i_wr_idx] <= i_wr_data;
    if (i_wr_en && (i_wr_both ||  i_wr_bank)) r_bank1[i_wr_idx] <= i_wr_data;
  end

  // The copy port is pre-read on the swap edge, when that same cell may be written.
  assign w_cp_hit = i_wr_en && (i_wr_both || (i_wr_bank == i_cp_bank)) &&
                    (i_wr_idx == i_cp_idx);

  always_ff @(posedge clock) begin
    if (reset) begin
      o_vga_q <= '0;
      o_cp_q  <= '0;
    end else begin
      if (!i_vga_ok)      o_vga_q <= '0;
      else if (i_vga_bank) o_vga_q <= r_bank1[i_vga_idx];
      else                 o_vga_q <= r_bank0[i_vga_idx];

      if (w_cp_hit)       o_cp_q <= i_wr_data;
      else if (i_cp_bank) o_cp_q <= r_bank1[i_cp_idx];
      else                o_cp_q <= r_bank0[i_cp_idx];
    end
  end

endmodule

`default_nettype wire

// File: rtl/playfield_frame_sequencer.sv
// ============================================================================
// Module      : playfield_frame_sequencer
// Description : Double-buffered playfield with vsync swap, frame counter,
//               per-frame action pulses and divided gravity tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module playfield_frame_sequencer
  import petris_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS,
  parameter int CW       = DEF_CW,
  parameter int ACTIONS  = 3,
  parameter int FCW      = 11,
  parameter int TICK_DIV = 30
) (
  input  wire logic               clock,
  input  wire logic               reset,
  input  wire logic               vsync,
  input  wire logic [ACTIONS-1:0] actions,
  playfield_frame_sequencer_if.slave bus,
  output logic                    frame_start,
  output logic      [FCW-1:0]     frame_count,
  output logic      [ACTIONS-1:0] action_pulse,
  output logic                    gravity_tick,
  output logic                    swapped
);

  localparam int CELLS = COLS * ROWS;
  localparam int IW    = $clog2(CELLS);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int GW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [IW-1:0]    C_LAST      = IW'(CELLS - 1);
  localparam logic [COL_W-1:0] C_COL_MAX   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] C_ROW_MAX   = ROW_W'(ROWS - 1);
  localparam logic [GW-1:0]    C_TICK_LAST = GW'(TICK_DIV - 1);

  seq_state_t         r_state, w_state_next;
  logic [IW-1:0]      r_idx, w_idx_next;
  logic               r_front_sel;
  logic               r_vsync_q;
  logic               r_commit_pend;
  logic [ACTIONS-1:0] r_acc;
  logic [GW-1:0]      r_grav_cnt;
  logic [FCW-1:0]     r_frame_count;
  logic               r_frame_start, r_swapped, r_gravity_tick;
  logic [ACTIONS-1:0] r_action_pulse;

  logic               w_edge, w_swap, w_wr_ok, w_rd_ok;
  logic [IW-1:0]      w_wr_idx, w_rd_idx;
  logic               w_ram_we, w_ram_both, w_ram_bank;
  logic [IW-1:0]      w_ram_idx, w_cp_idx;
  logic [CW-1:0]      w_ram_data, w_cp_q;
  logic               w_cp_bank;

  assign w_edge   = vsync && !r_vsync_q;
  assign w_swap   = w_edge && r_commit_pend && (r_state == ST_IDLE);
  assign w_wr_ok  = (bus.wr_col <= C_COL_MAX) && (bus.wr_row <= C_ROW_MAX);
  assign w_rd_ok  = (bus.rd_col <= C_COL_MAX) && (bus.rd_row <= C_ROW_MAX);
  assign w_wr_idx = IW'(int'(bus.wr_row) * COLS + int'(bus.wr_col));
  assign w_rd_idx = IW'(int'(bus.rd_row) * COLS + int'(bus.rd_col));

  assign bus.wr_ready = (r_state == ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // The copy read runs one cell ahead of the copy write; cell 0 is fetched
  // from the future front bank during the swap cycle itself.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_ram_we     = 1'b0;
    w_ram_both   = 1'b0;
    w_ram_bank   = !r_front_sel;
    w_ram_idx    = w_wr_idx;
    w_ram_data   = bus.wr_data;
    w_cp_bank    = !r_front_sel;
    w_cp_idx     = '0;
    case (r_state)
      ST_CLEAR: begin
        w_ram_we   = 1'b1;
        w_ram_both = 1'b1;
        w_ram_idx  = r_idx;
        w_ram_data = '0;
        if (r_idx == C_LAST) begin
          w_idx_next   = '0;
          w_state_next = ST_IDLE;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      ST_IDLE: begin
        w_ram_we   = bus.wr_en && w_wr_ok;
        w_idx_next = '0;
        if (w_swap) w_state_next = ST_COPY;
      end
      ST_COPY: begin
        w_ram_we   = 1'b1;
        w_ram_idx  = r_idx;
        w_ram_data = w_cp_q;
        w_cp_bank  = r_front_sel;
        if (r_idx == C_LAST) begin
          w_idx_next   = '0;
          w_state_next = ST_IDLE;
        end else begin
          w_cp_idx   = r_idx + 1'b1;
          w_idx_next = r_idx + 1'b1;
        end
      end
      default: w_state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vsync_q      <= 1'b1;
      r_front_sel    <= 1'b0;
      r_commit_pend  <= 1'b0;
      r_acc          <= '0;
      r_grav_cnt     <= '0;
      r_frame_count  <= '0;
      r_frame_start  <= 1'b0;
      r_swapped      <= 1'b0;
      r_gravity_tick <= 1'b0;
      r_action_pulse <= '0;
    end else begin
      r_vsync_q      <= vsync;
      r_frame_start  <= w_edge;
      r_swapped      <= w_swap;
      r_gravity_tick <= 1'b0;
      if (w_swap) begin
        r_front_sel   <= !r_front_sel;
        r_commit_pend <= bus.commit;
      end else if (bus.commit) begin
        r_commit_pend <= 1'b1;
      end
      if (w_edge) begin
        r_frame_count  <= r_frame_count + 1'b1;
        r_action_pulse <= r_acc | actions;
        r_acc          <= '0;
        if (r_grav_cnt == C_TICK_LAST) begin
          r_grav_cnt     <= '0;
          r_gravity_tick <= 1'b1;
        end else begin
          r_grav_cnt <= r_grav_cnt + 1'b1;
        end
      end else begin
        r_acc <= r_acc | actions;
      end
    end
  end

  assign frame_start  = r_frame_start;
  assign frame_count  = r_frame_count;
  assign action_pulse = r_action_pulse;
  assign gravity_tick = r_gravity_tick;
  assign swapped      = r_swapped;

  playfield_bank_ram #(
    .CELLS (CELLS),
    .CW    (CW)
  ) u_bank_ram (
    .clock      (clock),
    .reset      (reset),
    .i_wr_en    (w_ram_we),
    .i_wr_both  (w_ram_both),
    .i_wr_bank  (w_ram_bank),
    .i_wr_idx   (w_ram_idx),
    .i_wr_data  (w_ram_data),
    .i_vga_bank (r_front_sel),
    .i_vga_idx  (w_rd_idx),
    .i_vga_ok   (w_rd_ok),
    .o_vga_q    (bus.rd_pixel),
    .i_cp_bank  (w_cp_bank),
    .i_cp_idx   (w_cp_idx),
    .o_cp_q     (w_cp_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_playfield_frame_sequencer.sv
// ============================================================================
// Module      : tb_playfield_frame_sequencer
// Description : Self-checking bench: logical front/back playfield model plus
//               directed frame, swap, action and counter vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_playfield_frame_sequencer;

  localparam int NC = 10, NR = 20, N = 200, TDIV = 3, FMOD = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       vsync;
  logic [2:0] actions;
  logic       frame_start, gravity_tick, swapped;
  logic [3:0] frame_count;
  logic [2:0] action_pulse;

  playfield_frame_sequencer_if #(.COLS(NC), .ROWS(NR), .CW(3)) bus ();

  playfield_frame_sequencer #(
    .COLS(NC), .ROWS(NR), .CW(3), .ACTIONS(3), .FCW(4), .TICK_DIV(TDIV)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .vsync        (vsync),
    .actions      (actions),
    .bus          (bus),
    .frame_start  (frame_start),
    .frame_count  (frame_count),
    .action_pulse (action_pulse),
    .gravity_tick (gravity_tick),
    .swapped      (swapped)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Logical model: front/back are contents, not banks; a swap makes the
  // front equal to the back, and the back already matches it afterwards.
  logic [2:0] m_front [N];
  logic [2:0] m_back  [N];
  bit         m_live = 0, m_cleared, m_pend, m_vs_prev, m_edge, m_idle, m_sw;
  int         m_busy, m_frames;
  logic [2:0] m_acc;
  logic       e_fs, e_sw, e_tick, e_ready, e_rd_valid, e_ap_valid;
  logic [3:0] e_fc;
  logic [2:0] e_ap, e_rd;

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        m_live = 1; m_cleared = 0; m_pend = 0; m_vs_prev = 1;
        m_busy = N; m_frames = 0; m_acc = '0;
        for (int i = 0; i < N; i++) begin m_front[i] = '0; m_back[i] = '0; end
        e_fs = 0; e_sw = 0; e_tick = 0; e_ready = 0; e_fc = '0;
        e_ap = '0; e_ap_valid = 1; e_rd = '0; e_rd_valid = 1;
      end else if (m_live) begin
        m_edge = vsync && !m_vs_prev;
        m_idle = (m_busy == 0);
        if (m_idle) m_cleared = 1;
        m_sw = m_edge && m_pend && m_idle;
        e_rd_valid = m_cleared;
        if (int'(bus.rd_col) < NC && int'(bus.rd_row) < NR)
          e_rd = m_front[int'(bus.rd_row) * NC + int'(bus.rd_col)];
        else
          e_rd = '0;
        if (m_idle && bus.wr_en && int'(bus.wr_col) < NC && int'(bus.wr_row) < NR)
          m_back[int'(bus.wr_row) * NC + int'(bus.wr_col)] = bus.wr_data;
        if (m_sw) begin
          m_front = m_back;
          m_pend  = bus.commit;
        end else if (bus.commit) begin
          m_pend = 1;
        end
        m_busy = (m_busy > 0) ? m_busy - 1 : 0;
        if (m_sw) m_busy = N;
        e_ap_valid = m_edge;
        if (m_edge) begin
          m_frames++;
          e_ap  = m_acc | actions;
          m_acc = '0;
        end else begin
          m_acc = m_acc | actions;
        end
        e_fs    = m_edge;
        e_sw    = m_sw;
        e_tick  = m_edge && (m_frames % TDIV == 0);
        e_fc    = 4'(m_frames % FMOD);
        e_ready = (m_busy == 0);
        m_vs_prev = vsync;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (m_live) begin
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("swapped", 32'(swapped), 32'(e_sw));
        chk("gravity_tick", 32'(gravity_tick), 32'(e_tick));
        chk("frame_count", 32'(frame_count), 32'(e_fc));
        chk("wr_ready", 32'(bus.wr_ready), 32'(e_ready));
        if (e_rd_valid) chk("rd_pixel", 32'(bus.rd_pixel), 32'(e_rd));
        if (e_ap_valid) chk("action_pulse", 32'(action_pulse), 32'(e_ap));
      end
    end
  end

  task automatic step(input int k = 1);
    repeat (k) @(negedge clock);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.wr_ready && n < 1000) begin n++; @(negedge clock); end
  endtask

  // Returns at the negedge of the frame_start cycle.
  task automatic vs_pulse(input logic [2:0] act);
    vsync = 1'b1; actions = act;
    step();
    vsync = 1'b0; actions = '0;
  endtask

  task automatic rd(input int c, input int r, input logic [2:0] exp, input string name);
    bus.rd_col = 4'(c); bus.rd_row = 5'(r);
    step();
    chk(name, 32'(bus.rd_pixel), 32'(exp));
  endtask

  task automatic wr(input int c, input int r, input logic [2:0] d);
    bus.wr_en = 1'b1; bus.wr_col = 4'(c); bus.wr_row = 5'(r); bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic commit_pulse();
    bus.commit = 1'b1; step(); bus.commit = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int         n;
  logic [6:0] tick_mask;

  initial begin
    reset = 1'b1; vsync = 1'b0; actions = '0;
    bus.wr_en = 1'b0; bus.wr_col = '0; bus.wr_row = '0; bus.wr_data = '0;
    bus.commit = 1'b0; bus.rd_col = '0; bus.rd_row = '0;
    step(3);
    chk("reset_frame_count", 32'(frame_count), 0);
    chk("reset_wr_ready", 32'(bus.wr_ready), 0);
    reset = 1'b0;
    wait_ready(n);
    chk("clear_cycles", n, 200);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        rd(c, r, 3'd0, "clear_cell");
    chk("frame_count_after_clear", 32'(frame_count), 0);

    // Write, out-of-range write (aliases flat index of (1,6)), commit, swap.
    wr(3, 5, 3'b101);
    wr(11, 5, 3'b111);
    commit_pulse();
    step(3);
    vs_pulse(3'b000);
    chk("swap_frame_start", 32'(frame_start), 1);
    chk("swap_swapped", 32'(swapped), 1);
    bus.rd_col = 4'd3; bus.rd_row = 5'd5;
    n = 0;
    while (!bus.wr_ready && n < 1000) begin
      if (n == 1) chk("swap_read", 32'(bus.rd_pixel), 5);
      n++; step();
    end
    chk("copy_cycles", n, 200);
    rd(1, 6, 3'd0, "oob_write_dropped");
    rd(13, 4, 3'd0, "oob_read_zero");

    // Swap back: the former back bank must hold the copied cell.
    commit_pulse();
    vs_pulse(3'b000);
    chk("swap2_swapped", 32'(swapped), 1);
    rd(3, 5, 3'd5, "back_after_copy");
    wait_ready(n);
    chk("copy2_cycles", n, 199);

    // Vsync with nothing committed.
    step(5);
    vs_pulse(3'b000);
    chk("nocommit_frame_start", 32'(frame_start), 1);
    chk("nocommit_swapped", 32'(swapped), 0);
    chk("nocommit_ready", 32'(bus.wr_ready), 1);
    rd(3, 5, 3'd5, "front_unchanged");

    // Commit during COPY, vsync mid-COPY is deferred.
    commit_pulse();
    vs_pulse(3'b000);
    chk("swap3_swapped", 32'(swapped), 1);
    step(20);
    commit_pulse();
    step(20);
    vs_pulse(3'b000);
    chk("deferred_frame_start", 32'(frame_start), 1);
    chk("deferred_no_swap", 32'(swapped), 0);
    wait_ready(n);
    step(2);
    // Write accepted on the swap edge shows up in the new front.
    vsync = 1'b1;
    bus.wr_en = 1'b1; bus.wr_col = 4'd7; bus.wr_row = 5'd19; bus.wr_data = 3'b011;
    step();
    vsync = 1'b0; bus.wr_en = 1'b0;
    chk("deferred_swap", 32'(swapped), 1);
    rd(7, 19, 3'b011, "swap_edge_write");
    wait_ready(n);

    // Actions accumulated over a frame.
    step(5);
    actions = 3'b001; step(); actions = 3'b000;
    step(3);
    vs_pulse(3'b010);
    chk("action_pulse_or", 32'(action_pulse), 3'b011);
    step(4);
    vs_pulse(3'b000);
    chk("action_pulse_clear", 32'(action_pulse), 3'b000);

    // Reset with vsync held high: no edge; then gravity and frame wrap.
    reset = 1'b1; vsync = 1'b1;
    step(2);
    reset = 1'b0;
    step();
    chk("no_edge_after_reset", 32'(frame_start), 0);
    vsync = 1'b0;
    wait_ready(n);
    tick_mask = '0;
    for (int i = 1; i <= 17; i++) begin
      vs_pulse(3'b000);
      if (i <= 7) tick_mask[i-1] = gravity_tick;
      step(2);
    end
    chk("gravity_frames", 32'(tick_mask), 7'b0100100);
    chk("frame_wrap", 32'(frame_count), 1);

    // Reset aborts COPY and reclears everything.
    commit_pulse();
    vs_pulse(3'b000);
    step(50);
    reset = 1'b1; step(); reset = 1'b0;
    wait_ready(n);
    chk("reset_mid_copy_clear", n, 200);
    rd(7, 19, 3'd0, "cleared_after_reset");

    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
